// File: rtl/maple_in_if.sv
// Byte handoff from the Maple receiver to the register/FIFO layer.
interface maple_in_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;

  modport master (output data, output data_valid, input data_ack);
  modport slave  (input data, input data_valid, output data_ack);
endinterface

// File: rtl/maple_in.sv
// Maple bus receiver: decodes start/data/end patterns on SDCKA (pin1) / SDCKB (pin5).
// Optional MAPLE_IN_XOR_EN adds a per-frame running XOR check reported on xor_ok.
module maple_in #(
  parameter int unsigned START_PULSES = 4,
  parameter int unsigned END_PULSES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin1,
  input  logic       pin5,
  input  logic       arm,
  maple_in_if.master rx,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err,
  output logic       xor_ok
);
  localparam int unsigned SCW = $clog2(START_PULSES + 2);
  localparam int unsigned ECW = $clog2(END_PULSES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_END_WAIT} state_e;

  state_e         state_q;
  logic [1:0]     p1_sync_q, p5_sync_q;
  logic           p1_prev_q, p5_prev_q;
  logic [SCW-1:0] pcnt_q;
  logic [ECW-1:0] endcnt_q;
  logic [2:0]     bitcnt_q, spec_cnt_q;
  logic           phase_q;
  logic [6:0]     shreg_q;
  logic [7:0]     data_q;
  logic           valid_q, overrun_q, busy_q;
  logic           frame_start_q, frame_end_q, frame_err_q;

  logic p1, p5, p1_fall, p1_rise, p5_fall, p5_rise, both_edge;
  logic start_go, end_go, end_hit, shift_en, shift_bit, commit;
  logic [7:0] byte_w;
  logic [2:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_sync_q <= '1;
      p5_sync_q <= '1;
      p1_prev_q <= 1'b1;
      p5_prev_q <= 1'b1;
    end else begin
      p1_sync_q <= {p1_sync_q[0], pin1};
      p5_sync_q <= {p5_sync_q[0], pin5};
      p1_prev_q <= p1_sync_q[1];
      p5_prev_q <= p5_sync_q[1];
    end
  end

  assign p1        = p1_sync_q[1];
  assign p5        = p5_sync_q[1];
  assign p1_fall   = p1_prev_q & ~p1;
  assign p1_rise   = ~p1_prev_q & p1;
  assign p5_fall   = p5_prev_q & ~p5;
  assign p5_rise   = ~p5_prev_q & p5;
  assign both_edge = (p1_fall | p1_rise) & (p5_fall | p5_rise);

  assign start_go = arm && (state_q == S_START) && p1_rise && (pcnt_q == SCW'(START_PULSES));
  assign end_go   = arm && (state_q == S_END_WAIT) && p5_rise;
  assign byte_w   = {shreg_q, shift_bit};
  // The first pin1 fall of an end pattern already took a bit; judge the byte by the count before it.
  assign err_cnt  = (endcnt_q == '0) ? bitcnt_q : spec_cnt_q;

  always_comb begin
    end_hit   = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    commit    = 1'b0;
    if (arm && (state_q == S_DATA) && !both_edge) begin
      end_hit = p1_fall && !(p5_fall || p5_rise) && (endcnt_q == ECW'(END_PULSES - 1));
      if (!end_hit) begin
        if (!phase_q && p1_fall) begin
          shift_en  = 1'b1;
          shift_bit = p5;
        end else if (phase_q && p5_fall) begin
          shift_en  = 1'b1;
          shift_bit = p1;
        end
      end
      commit = shift_en && (bitcnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pcnt_q        <= '0;
      endcnt_q      <= '0;
      bitcnt_q      <= '0;
      spec_cnt_q    <= '0;
      phase_q       <= 1'b0;
      shreg_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_start_q <= start_go;
      frame_end_q   <= end_go;
      frame_err_q   <= 1'b0;

      if (rx.data_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (commit) begin
        if (!valid_q || rx.data_ack) begin
          data_q  <= byte_w;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
      if (shift_en) begin
        shreg_q  <= byte_w[6:0];
        bitcnt_q <= bitcnt_q + 1'b1;
        phase_q  <= ~phase_q;
      end

      if (!arm) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        bitcnt_q    <= '0;
        frame_err_q <= busy_q;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (both_edge) begin
              frame_err_q <= 1'b1;
            end else if (p1_fall && p5) begin
              state_q <= S_START;
              pcnt_q  <= '0;
            end
          end
          S_START: begin
            if (start_go) begin
              state_q  <= S_DATA;
              busy_q   <= 1'b1;
              bitcnt_q <= '0;
              phase_q  <= 1'b0;
              endcnt_q <= '0;
            end else if (p1_rise) begin
              state_q     <= S_IDLE;
              frame_err_q <= 1'b1;
            end else if (p5_fall && !p1 && (pcnt_q != SCW'(START_PULSES + 1))) begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end
          S_DATA: begin
            if (both_edge) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              bitcnt_q    <= '0;
              frame_err_q <= 1'b1;
            end else if (p5_fall || p5_rise) begin
              endcnt_q <= '0;
            end else if (p1_fall) begin
              if (endcnt_q == '0) spec_cnt_q <= bitcnt_q;
              if (end_hit) begin
                state_q  <= S_END_WAIT;
                endcnt_q <= '0;
                bitcnt_q <= '0;
                if (err_cnt != 3'd0) frame_err_q <= 1'b1;
              end else begin
                endcnt_q <= endcnt_q + 1'b1;
              end
            end
          end
          S_END_WAIT: begin
            if (end_go) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MAPLE_IN_XOR_EN
  logic [7:0] xacc_q;
  logic       xor_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xacc_q   <= '0;
      xor_ok_q <= 1'b0;
    end else if (start_go) begin
      xacc_q   <= '0;
      xor_ok_q <= 1'b0;
    end else begin
      if (commit) xacc_q <= xacc_q ^ byte_w;
      if (end_go) xor_ok_q <= (xacc_q == 8'h00);
    end
  end

  assign xor_ok = xor_ok_q;
`else
  assign xor_ok = 1'b0;
`endif

  assign rx.data       = data_q;
  assign rx.data_valid = valid_q;
  assign frame_start   = frame_start_q;
  assign frame_end     = frame_end_q;
  assign frame_err     = frame_err_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_maple_in.sv
// Scoreboard bench for maple_in: stimulus queues expected events, a monitor pops and compares.
module tb_maple_in;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin1 = 1'b1;
  logic pin5 = 1'b1;
  logic arm = 1'b1;
  logic frame_start, frame_end, busy, overrun, frame_err, xor_ok;

  maple_in_if rx_if ();

  maple_in #(.START_PULSES(4), .END_PULSES(2)) dut (
    .clk(clk), .rst(rst), .pin1(pin1), .pin5(pin5), .arm(arm), .rx(rx_if),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .xor_ok(xor_ok)
  );

  always #5 clk = ~clk;

  localparam int unsigned EV_START = 0, EV_BYTE = 1, EV_END = 2, EV_ERR = 3;
`ifdef MAPLE_IN_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  typedef struct {
    int unsigned kind;
    logic [7:0]  val;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        auto_ack = 1'b1;
  logic        phase_b = 1'b0;
  logic        prev_v = 1'b0;
  logic [7:0]  bx = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int unsigned kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int unsigned kind, input logic [7:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == EV_BYTE || kind == EV_END) chk("event_val", {24'd0, val}, {24'd0, e.val});
    end
  endtask

  function automatic logic [7:0] xexp(input logic [7:0] acc);
    return {7'd0, XOR_EN && (acc == 8'h00)};
  endfunction

  // Monitor: compares every DUT event against the scoreboard and acks bytes.
  initial begin
    rx_if.data_ack = 1'b0;
    forever begin
      @(negedge clk);
      rx_if.data_ack = 1'b0;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (frame_start) got_ev(EV_START, 8'h00);
        if (rx_if.data_valid && !prev_v) got_ev(EV_BYTE, rx_if.data);
        if (frame_err) got_ev(EV_ERR, 8'h00);
        if (frame_end) got_ev(EV_END, {7'd0, xor_ok});
        if (rx_if.data_valid && auto_ack) rx_if.data_ack = 1'b1;
        prev_v = rx_if.data_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  task automatic set1(input logic v);
    @(posedge clk); #1;
    pin1 = v;
    repeat (4) @(posedge clk);
  endtask

  task automatic set5(input logic v);
    @(posedge clk); #1;
    pin5 = v;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_start(input int unsigned n);
    if (!pin1) set1(1'b1);
    if (!pin5) set5(1'b1);
    set1(1'b0);
    repeat (n) begin
      set5(1'b0);
      set5(1'b1);
    end
    set1(1'b1);
    phase_b = 1'b0;
    bx = 8'h00;
  endtask

  task automatic send_bit(input logic b);
    if (!phase_b) begin
      if (!pin1) set1(1'b1);
      if (pin5 != b) set5(b);
      set1(1'b0);
    end else begin
      if (!pin5) set5(1'b1);
      if (pin1 != b) set1(b);
      set5(1'b0);
    end
    phase_b = ~phase_b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    bx = bx ^ b;
  endtask

  // Requires pin5 low on entry so the closing pin5 rise is a real edge.
  task automatic send_end();
    if (!pin1) set1(1'b1);
    set1(1'b0);
    set1(1'b1);
    set1(1'b0);
    set5(1'b1);
    phase_b = 1'b0;
  endtask

  task automatic drain(input string nm);
    repeat (6) @(posedge clk);
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic xor_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes[3];
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    push(EV_START, 8'h00);
    send_start(4);
    for (int i = 0; i < 3; i++) begin
      push(EV_BYTE, bytes[i]);
      send_byte(bytes[i]);
    end
    push(EV_END, xexp(bx));
    send_end();
    drain("xor_frame_pending");
    chk("xor_frame_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", {24'd0, rx_if.data}, 0);
    chk("rst_valid", {31'd0, rx_if.data_valid}, 0);
    chk("rst_frame_start", {31'd0, frame_start}, 0);
    chk("rst_frame_end", {31'd0, frame_end}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_xor_ok", {31'd0, xor_ok}, 0);

    // Good frame, two bytes, immediate ack.
    push(EV_START, 8'h00);
    send_start(4);
    chk("start_busy", {31'd0, busy}, 1);
    push(EV_BYTE, 8'hA5);
    send_byte(8'hA5);
    push(EV_BYTE, 8'h3C);
    send_byte(8'h3C);
    push(EV_END, xexp(bx));
    send_end();
    drain("frame1_pending");
    chk("frame1_busy_after_end", {31'd0, busy}, 0);

    // Short start: three pulses only.
    push(EV_ERR, 8'h00);
    send_start(3);
    drain("short_start_pending");
    chk("short_start_busy", {31'd0, busy}, 0);

    // Three bytes without ack: first byte held, later ones overrun.
    auto_ack = 1'b0;
    push(EV_START, 8'h00);
    send_start(4);
    push(EV_BYTE, 8'hA5);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (4) @(posedge clk);
    chk("ovr_data", {24'd0, rx_if.data}, 32'hA5);
    chk("ovr_valid", {31'd0, rx_if.data_valid}, 1);
    chk("ovr_flag", {31'd0, overrun}, 1);
    auto_ack = 1'b1;
    repeat (4) @(posedge clk);
    chk("ovr_valid_after_ack", {31'd0, rx_if.data_valid}, 0);
    chk("ovr_flag_after_ack", {31'd0, overrun}, 0);
    push(EV_END, xexp(bx));
    send_end();
    drain("ovr_pending");

    // End pattern after five bits: framing error, no byte, frame_end still pulses.
    push(EV_START, 8'h00);
    send_start(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    push(EV_ERR, 8'h00);
    push(EV_END, xexp(bx));
    send_end();
    drain("partial_pending");
    chk("partial_valid", {31'd0, rx_if.data_valid}, 0);

    // XOR check byte frames.
    xor_frame(8'h12, 8'h34, 8'h26);
    xor_frame(8'h12, 8'h34, 8'h27);

    // Abort mid-frame by dropping arm.
    push(EV_START, 8'h00);
    send_start(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    push(EV_ERR, 8'h00);
    @(posedge clk); #1 arm = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    set1(1'b1);
    set5(1'b1);
    @(posedge clk); #1 arm = 1'b1;
    phase_b = 1'b0;
    drain("abort_pending");

    // Reset while a byte is pending.
    auto_ack = 1'b0;
    push(EV_START, 8'h00);
    send_start(4);
    push(EV_BYTE, 8'h5A);
    send_byte(8'h5A);
    repeat (4) @(posedge clk);
    chk("pre_rst_valid", {31'd0, rx_if.data_valid}, 1);
    @(posedge clk); #1;
    rst  = 1'b1;
    pin1 = 1'b1;
    pin5 = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    phase_b = 1'b0;
    auto_ack = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, rx_if.data_valid}, 0);
    chk("midrst_data", {24'd0, rx_if.data}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    drain("midrst_pending");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
